// File: rtl/axi4lite_wb_pkg.sv
// axi4lite_wb_pkg: shared state encoding, response codes and data width for the AXI4-Lite to Wishbone bridge
package axi4lite_wb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int WB_DATA_WIDTH = 32;
endpackage

// File: rtl/wb_timeout_cnt.sv
// wb_timeout_cnt: counts busy cycles and flags expiry on the LIMIT-th cycle without a WB termination
module wb_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] cnt;
  assign expired = en && cnt == CW'(LIMIT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/axi4lite_wb_bridge.sv
// axi4lite_wb_bridge: AXI4-Lite slave to pipelined Wishbone B4 master, one WB transaction at a time.
// Define WB_TIMEOUT_EN to abort unanswered WB cycles with SLVERR after TIMEOUT_CYCLES.
module axi4lite_wb_bridge
  import axi4lite_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     awvalid_i,
  output logic                     awready_o,
  input  logic [ADDR_WIDTH-1:0]    awaddr_i,
  input  logic                     wvalid_i,
  output logic                     wready_o,
  input  logic [WB_DATA_WIDTH-1:0] wdata_i,
  input  logic [3:0]               wstrb_i,
  output logic                     bvalid_o,
  input  logic                     bready_i,
  output logic [1:0]               bresp_o,
  input  logic                     arvalid_i,
  output logic                     arready_o,
  input  logic [ADDR_WIDTH-1:0]    araddr_i,
  output logic                     rvalid_o,
  input  logic                     rready_i,
  output logic [WB_DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]               rresp_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic                     wb_we_o,
  output logic [ADDR_WIDTH-3:0]    wb_adr_o,
  output logic [3:0]               wb_sel_o,
  output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
  input  logic                     wb_ack_i,
  input  logic                     wb_err_i,
  input  logic                     wb_rty_i,
  input  logic                     wb_stall_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_dat_i
);
  state_t state;
  logic aw_full, w_full, last_wr, cur_wr;
  logic [ADDR_WIDTH-3:0] aw_adr;
  logic [WB_DATA_WIDTH-1:0] w_data;
  logic [3:0] w_strb;
  logic idle, busy, lat_ok, wr_pend, rd_grant, wr_grant, fail, term, tmo;
  logic unused_bits;
  assign unused_bits = &{1'b0, awaddr_i[1:0], araddr_i[1:0]};
  assign idle = state == IDLE;
  assign busy = state == REQ || state == WAIT;
  // Latches stay open during a read so the next write can queue behind it
  assign lat_ok = !rst_i && (idle || !cur_wr);
  assign awready_o = lat_ok && !aw_full;
  assign wready_o = lat_ok && !w_full;
  assign wr_pend = aw_full && w_full;
  assign rd_grant = idle && arvalid_i && (!wr_pend || last_wr);
  assign wr_grant = idle && wr_pend && !rd_grant;
  assign arready_o = !rst_i && rd_grant;
  assign fail = wb_err_i || wb_rty_i || tmo;
  assign term = wb_ack_i || fail;
`ifdef WB_TIMEOUT_EN
  wb_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk_i), .rst(rst_i), .load(!busy), .en(busy), .expired(tmo)
  );
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      aw_full <= 1'b0;
      w_full <= 1'b0;
      last_wr <= 1'b0;
      cur_wr <= 1'b0;
      aw_adr <= '0;
      w_data <= '0;
      w_strb <= '0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o <= 1'b0;
      wb_adr_o <= '0;
      wb_sel_o <= '0;
      wb_dat_o <= '0;
      bvalid_o <= 1'b0;
      bresp_o <= RESP_OKAY;
      rvalid_o <= 1'b0;
      rresp_o <= RESP_OKAY;
      rdata_o <= '0;
    end else begin
      if (awvalid_i && awready_o) begin
        aw_full <= 1'b1;
        aw_adr <= awaddr_i[ADDR_WIDTH-1:2];
      end
      if (wvalid_i && wready_o) begin
        w_full <= 1'b1;
        w_data <= wdata_i;
        w_strb <= wstrb_i;
      end
      case (state)
        IDLE: if (rd_grant || wr_grant) begin
          state <= REQ;
          cur_wr <= wr_grant;
          last_wr <= wr_grant;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          wb_we_o <= wr_grant;
          wb_adr_o <= wr_grant ? aw_adr : araddr_i[ADDR_WIDTH-1:2];
          wb_sel_o <= wr_grant ? w_strb : 4'hF;
          wb_dat_o <= wr_grant ? w_data : '0;
        end
        REQ, WAIT: if (term) begin
          state <= RESP;
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          bvalid_o <= cur_wr;
          rvalid_o <= !cur_wr;
          if (cur_wr) bresp_o <= fail ? RESP_SLVERR : RESP_OKAY;
          else begin
            rresp_o <= fail ? RESP_SLVERR : RESP_OKAY;
            rdata_o <= fail ? '0 : wb_dat_i;
          end
        end else if (!wb_stall_i) begin
          state <= WAIT;
          wb_stb_o <= 1'b0;
        end
        default: begin
          if (bvalid_o && bready_i) begin
            state <= IDLE;
            bvalid_o <= 1'b0;
            aw_full <= 1'b0;
            w_full <= 1'b0;
          end
          if (rvalid_o && rready_i) begin
            state <= IDLE;
            rvalid_o <= 1'b0;
          end
        end
      endcase
    end
endmodule

// File: doc/axi4lite_wb_bridge.md
Name: axi4lite_wb_bridge

Overview:
- AXI4-Lite slave to pipelined Wishbone B4 master bridge, 32-bit data.
- Sits directly upstream of generated WB register banks; its wb_* outputs drive the bank's wb_* inputs.
- Serialises reads and writes: exactly one WB transaction is outstanding at any time.
- Maps WB ack to OKAY and WB err/rty to SLVERR.

Parameters:
ADDR_WIDTH, 4, byte-address width; WB address is bits [ADDR_WIDTH-1:2]
TIMEOUT_CYCLES, 255, WB ack wait limit, used only with WB_TIMEOUT_EN

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
awvalid_i  in  1  AXI write address valid
awready_o  out  1  AXI write address ready
awaddr_i  in  ADDR_WIDTH  write byte address
wvalid_i  in  1  write data valid
wready_o  out  1  write data ready
wdata_i  in  32  write data
wstrb_i  in  4  write byte strobes
bvalid_o  out  1  write response valid
bready_i  in  1  write response ready
bresp_o  out  2  write response
arvalid_i  in  1  read address valid
arready_o  out  1  read address ready
araddr_i  in  ADDR_WIDTH  read byte address
rvalid_o  out  1  read data valid
rready_i  in  1  read data ready
rdata_o  out  32  read data
rresp_o  out  2  read response
wb_cyc_o  out  1  WB cycle
wb_stb_o  out  1  WB strobe
wb_we_o  out  1  WB write enable
wb_adr_o  out  ADDR_WIDTH-2  WB word address
wb_sel_o  out  4  WB byte select
wb_dat_o  out  32  WB write data
wb_ack_i  in  1  WB ack
wb_err_i  in  1  WB error
wb_rty_i  in  1  WB retry
wb_stall_i  in  1  WB stall
wb_dat_i  in  32  WB read data

Behaviour:
- Reset (async, rst_i=1): all outputs 0, FSM in IDLE, AW/W latches empty, last_wr=0.
- AW and W channels latch independently:
  - awready_o=1 in IDLE while AW latch is empty; wready_o=1 in IDLE while W latch is empty.
  - Handshake (valid & ready) stores address or data+strobe and sets the corresponding full flag.
- Write pending = AW full and W full. Read pending = arvalid_i in IDLE.
- Arbitration in IDLE, round-robin: if both are pending, read wins when last_wr=1, write wins otherwise. last_wr updates on each grant.
- arready_o=1 only in the IDLE cycle in which the read is granted. The AR handshake takes araddr_i.
- FSM:
  - IDLE -> REQ on grant. cyc/stb/we/adr/sel/dat are registered and valid the next cycle.
    - Write: sel = latched strobe, dat = latched data.
    - Read: sel = 4'b1111, dat = 0.
  - REQ: cyc=1, stb=1. If wb_stall_i=0, stb drops next cycle -> WAIT. An ack/err/rty in the same cycle is accepted -> RESP.
  - WAIT: cyc=1, stb=0. On ack/err/rty: cyc drops, response captured -> RESP. Read: rdata_o = wb_dat_i, or 0 on error.
  - RESP: bvalid_o or rvalid_o is held with stable resp/data until the matching ready, then -> IDLE. Write completion clears both latches.
- Response codes: ack -> 2'b00 (OKAY); err or rty -> 2'b10 (SLVERR). If ack and err arrive together, err takes priority.
- Latency: an AXI request completes in 3 cycles minimum from valid to b/rvalid, with zero stall and ack on the first cycle after stb.
- AW/W latching while not IDLE: AW/W latches may fill during a read, because ready is deasserted only once the latch is full. Correction: awready_o/wready_o are also allowed in REQ/WAIT/RESP while a read is in progress. They are never allowed during a write.
- rst_i mid-transaction aborts immediately: cyc drops, responses are dropped, latches are cleared.

Optional Feature:
- Macro WB_TIMEOUT_EN.
- Defined: a counter runs in REQ/WAIT. Once TIMEOUT_CYCLES cycles pass with no ack/err/rty:
  - drop cyc/stb,
  - return SLVERR (rdata 0),
  - go to RESP.
  - The counter clears on leaving WAIT.
- Undefined: no counter; the bridge waits indefinitely.

Decomposition:
- Package axi4lite_wb_pkg:
  - state enum {IDLE, REQ, WAIT, RESP},
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10,
  - WB_DATA_WIDTH=32.
- Sub-module wb_timeout_cnt (load/enable/expired), instantiated only under WB_TIMEOUT_EN.

Test Plan:
- Write: AW addr 0x4 and W data 0x15 with strb 0xF in the same cycle; slave ack 1 cycle after stb -> wb_adr_o=2'b01, wb_sel_o=0xF, wb_we_o=1; bvalid with bresp 00.
- W arrives 3 cycles before AW, strb 0x1 -> single WB write with sel 0x1 after AW lands; no duplicate stb.
- Read addr 0x8, wb_stall_i high 2 cycles, wb_dat_i=0x5 -> stb held 3 cycles; rdata 0x5, rresp 00; rvalid stays high while rready=0 for 4 cycles.
- Read and write pending simultaneously, twice in succession -> grants alternate write, read, write, read from reset (last_wr=0).
- wb_err_i instead of ack on a write -> bresp 10; under WB_TIMEOUT_EN with no ack and TIMEOUT_CYCLES=8 -> cyc drops after 8 cycles, rresp 10, rdata 0.
- rst_i asserted during WAIT -> cyc/stb/bvalid/rvalid 0 asynchronously; the next read completes normally.
